// File: rtl/snd_pkg.sv
// snd_pkg: shared I2S frame geometry and defaults for the sound transmit path.
package snd_pkg;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS = 32;
  localparam int LRCK_RISE = 31;
  localparam int LRCK_FALL = 63;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_MCLK_PER_BCLK = 4;
  typedef logic [$clog2(FRAME_BITS)-1:0] bit_idx_t;
  function automatic logic lrck_at(bit_idx_t n);
    return n >= bit_idx_t'(LRCK_RISE) && n < bit_idx_t'(LRCK_FALL);
  endfunction
endpackage

// File: rtl/snd_i2s_clkdiv.sv
// snd_i2s_clkdiv: divides SND_MCLK into BCLK/LRCK and strobes bit and frame boundaries.
module snd_i2s_clkdiv
  import snd_pkg::*;
#(
  parameter int MCLK_PER_BCLK = DEF_MCLK_PER_BCLK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic bclk,
  output logic lrck,
  output logic frame_start,
  output logic bit_tick
);
  localparam int CW = $clog2(MCLK_PER_BCLK);
  logic [CW-1:0] mclk_cnt, cnt_nxt;
  bit_idx_t bit_n, bit_nxt;
  assign bit_tick = enable && mclk_cnt == CW'(MCLK_PER_BCLK - 1);
  assign frame_start = bit_tick && bit_n == bit_idx_t'(FRAME_BITS - 1);
  assign cnt_nxt = bit_tick ? '0 : mclk_cnt + 1'b1;
  assign bit_nxt = bit_tick ? bit_n + 1'b1 : bit_n;
  // Parking at the last MCLK of bit 63 makes the first enabled edge a frame start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mclk_cnt <= CW'(MCLK_PER_BCLK - 1);
      bit_n <= bit_idx_t'(FRAME_BITS - 1);
      bclk <= 1'b0;
      lrck <= 1'b0;
    end else if (!enable) begin
      mclk_cnt <= CW'(MCLK_PER_BCLK - 1);
      bit_n <= bit_idx_t'(FRAME_BITS - 1);
      bclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      mclk_cnt <= cnt_nxt;
      bit_n <= bit_nxt;
      bclk <= cnt_nxt >= CW'(MCLK_PER_BCLK / 2);
      lrck <= lrck_at(bit_nxt);
    end
endmodule

// File: rtl/snd_i2s_tx.sv
// snd_i2s_tx: Philips I2S transmitter with a one-pair holding buffer and underrun flag.
module snd_i2s_tx
  import snd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MCLK_PER_BCLK = DEF_MCLK_PER_BCLK
) (
  input  logic                  SND_MCLK,
  input  logic                  SND_RST_N,
  input  logic                  ENABLE,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_LEFT,
  input  logic [DATA_WIDTH-1:0] S_RIGHT,
  output logic                  I2S_BCLK,
  output logic                  I2S_LRCK,
  output logic                  I2S_SDATA,
  output logic                  UNDERRUN
);
  logic frame_start, bit_tick, hold_full, xfer, load;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [SLOT_BITS-1:0] slot_l, slot_r;
  logic [FRAME_BITS-1:0] frame, shreg;
  snd_i2s_clkdiv #(.MCLK_PER_BCLK(MCLK_PER_BCLK)) u_clkdiv (
    .clk(SND_MCLK),
    .rst_n(SND_RST_N),
    .enable(ENABLE),
    .bclk(I2S_BCLK),
    .lrck(I2S_LRCK),
    .frame_start,
    .bit_tick
  );
  assign S_READY = ~hold_full;
  assign xfer = S_VALID && !hold_full;
  assign load = frame_start && hold_full;
  assign slot_l = SLOT_BITS'(hold_l) << (SLOT_BITS - DATA_WIDTH);
  assign slot_r = SLOT_BITS'(hold_r) << (SLOT_BITS - DATA_WIDTH);
  assign frame = load ? {slot_l, slot_r} : '0;
  // The whole 64-bit frame, MSB first, so padding slots fall out as zeros.
  always_ff @(posedge SND_MCLK or negedge SND_RST_N)
    if (!SND_RST_N) begin
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      shreg <= '0;
      I2S_SDATA <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      UNDERRUN <= frame_start && !hold_full;
      hold_full <= xfer || (hold_full && !load);
      if (xfer) begin
        hold_l <= S_LEFT;
        hold_r <= S_RIGHT;
      end
      if (!ENABLE) I2S_SDATA <= 1'b0;
      else if (frame_start) {I2S_SDATA, shreg} <= {frame, 1'b0};
      else if (bit_tick) {I2S_SDATA, shreg} <= {shreg, 1'b0};
    end
endmodule

// File: tb/tb_snd_i2s_tx.sv
// tb_snd_i2s_tx: table vectors, corner sequences and a per-cycle arithmetic model for two configurations.
module tb_snd_i2s_tx;
  logic clk = 1'b0;
  logic rst_n, en, v0, v1;
  logic [23:0] l0, r0;
  logic [15:0] l1, r1;
  logic ready0, bclk0, lrck0, sdata0, und0;
  logic ready1, bclk1, lrck1, sdata1, und1;
  int tests = 0, fails = 0, cyc = 0, ucnt0 = 0, ucnt1 = 0;
  int mt[2], mxc[2];
  logic mfull[2], mund[2];
  logic [31:0] mhl[2], mhr[2], mfl[2], mfr[2];
  logic fb;

  always #5 clk = ~clk;

  snd_i2s_tx #(.DATA_WIDTH(24), .MCLK_PER_BCLK(4)) dut0 (
    .SND_MCLK(clk), .SND_RST_N(rst_n), .ENABLE(en), .S_VALID(v0), .S_READY(ready0),
    .S_LEFT(l0), .S_RIGHT(r0), .I2S_BCLK(bclk0), .I2S_LRCK(lrck0), .I2S_SDATA(sdata0),
    .UNDERRUN(und0));
  snd_i2s_tx #(.DATA_WIDTH(16), .MCLK_PER_BCLK(8)) dut1 (
    .SND_MCLK(clk), .SND_RST_N(rst_n), .ENABLE(en), .S_VALID(v1), .S_READY(ready1),
    .S_LEFT(l1), .S_RIGHT(r1), .I2S_BCLK(bclk1), .I2S_LRCK(lrck1), .I2S_SDATA(sdata1),
    .UNDERRUN(und1));

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic int pm(int i); return i ? 8 : 4; endfunction
  function automatic int pd(int i); return i ? 16 : 24; endfunction

  function automatic logic sg(int k);
    case (k)
      0: return bclk0;
      1: return lrck0;
      2: return sdata0;
      3: return bclk1;
      4: return lrck1;
      default: return sdata1;
    endcase
  endfunction

  // Expected {ready, bclk, lrck, sdata, underrun} from the edge count since enable.
  function automatic logic [4:0] expv(int i);
    int m, d, mc, b;
    logic sd;
    m = pm(i);
    d = pd(i);
    if (mt[i] < 0) return {~mfull[i], 4'b0};
    mc = mt[i] % m;
    b = (mt[i] / m) % 64;
    sd = b < d ? mfl[i][d-1-b] : (b >= 32 && b < 32 + d) ? mfr[i][d-1-(b-32)] : 1'b0;
    return {~mfull[i], mc >= m / 2, b >= 31 && b <= 62, sd, mund[i]};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mt[i] = -1; mfull[i] = 0; mund[i] = 0; mfl[i] = 0; mfr[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fb = mfull[i];
        mund[i] = 0;
        if (!en) mt[i] = -1;
        else begin
          mt[i]++;
          if (mt[i] % (64 * pm(i)) == 0) begin
            if (fb) begin
              mfl[i] = mhl[i]; mfr[i] = mhr[i]; mfull[i] = 0;
            end else begin
              mfl[i] = 0; mfr[i] = 0; mund[i] = 1;
            end
          end
        end
        if ((i ? v1 : v0) && !fb) begin
          mfull[i] = 1;
          mhl[i] = i ? 32'(l1) : 32'(l0);
          mhr[i] = i ? 32'(r1) : 32'(r0);
          mxc[i]++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("inst0 outputs", {59'b0, ready0, bclk0, lrck0, sdata0, und0}, {59'b0, expv(0)});
    chk("inst1 outputs", {59'b0, ready1, bclk1, lrck1, sdata1, und1}, {59'b0, expv(1)});
    ucnt0 += int'(und0);
    ucnt1 += int'(und1);
  end

  task automatic per(input int k, input int exp, input string nm);
    int c, r, t0;
    logic p;
    c = 0; r = 0; t0 = 0;
    p = sg(k);
    while (c < 2000 && r < 2) begin
      @(posedge clk); #1;
      if (sg(k) && !p) begin
        if (r == 0) t0 = c;
        r++;
      end
      p = sg(k);
      c++;
    end
    chk(nm, r == 2 ? 64'(c - 1 - t0) : 64'd0, 64'(exp));
  endtask

  task automatic cap(input int i, output logic [63:0] sd, output logic [63:0] lr);
    int n;
    logic pb;
    n = 0; sd = '0; lr = '0;
    pb = sg(3 * i);
    for (int c = 0; c < 1500 && n < 64; c++) begin
      @(posedge clk); #1;
      if (sg(3 * i) && !pb) begin
        sd = {sd[62:0], sg(3 * i + 2)};
        lr = {lr[62:0], sg(3 * i + 1)};
        n++;
      end
      pb = sg(3 * i);
    end
    if (n < 64) chk("capture timeout", 64'(n), 64'd64);
  endtask

  task automatic wfs(input int phase);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(mt[0] >= 0 && mt[0] % 256 == phase) && c < 2000);
    if (c >= 2000) chk("frame wait timeout", 64'(c), 64'd0);
  endtask

  typedef struct {
    int inst;
    logic [31:0] l, r, el, er;
  } vec_t;
  vec_t tv[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] sd, lr;
    int a, b, base, c, cy1, cy7;
    tv[0] = '{0, 32'h800001, 32'h7FFFFF, 32'h80000100, 32'h7FFFFF00};
    tv[1] = '{0, 32'h000000, 32'hFFFFFF, 32'h00000000, 32'hFFFFFF00};
    tv[2] = '{0, 32'h123456, 32'hABCDEF, 32'h12345600, 32'hABCDEF00};
    tv[3] = '{1, 32'h8001, 32'h7FFF, 32'h80010000, 32'h7FFF0000};
    tv[4] = '{1, 32'h1234, 32'hFEDC, 32'h12340000, 32'hFEDC0000};
    cy1 = 0; cy7 = 0;
    mxc[0] = 0; mxc[1] = 0;
    rst_n = 0; en = 0; v0 = 0; v1 = 0; l0 = 0; r0 = 0; l1 = 0; r1 = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset state", {59'b0, ready0, bclk0, lrck0, sdata0, und0}, 64'b10000);
    #1 rst_n = 1;
    // Free-running with no samples
    @(negedge clk); en = 1;
    per(0, 4, "bclk0 period");
    per(1, 256, "lrck0 period");
    per(3, 8, "bclk1 period");
    per(4, 512, "lrck1 period");
    @(negedge clk); #1 a = ucnt0; b = ucnt1;
    repeat (1024) @(negedge clk);
    #1 chk("idle underruns inst0", 64'(ucnt0 - a), 64'd4);
    chk("idle underruns inst1", 64'(ucnt1 - b), 64'd2);
    @(negedge clk); en = 0;
    repeat (2) @(negedge clk);
    // Preload-then-enable vectors
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (tv[k].inst == 0) begin
        l0 = tv[k].l[23:0]; r0 = tv[k].r[23:0]; v0 = 1;
      end else begin
        l1 = tv[k].l[15:0]; r1 = tv[k].r[15:0]; v1 = 1;
      end
      @(negedge clk); v0 = 0; v1 = 0; en = 1;
      cap(tv[k].inst, sd, lr);
      chk("table left slot", {32'b0, sd[63:32]}, {32'b0, tv[k].el});
      chk("table right slot", {32'b0, sd[31:0]}, {32'b0, tv[k].er});
      chk("table lrck pattern", lr, 64'h00000001FFFFFFFE);
      @(negedge clk); en = 0;
      repeat (2) @(negedge clk);
    end
    // Streaming with S_VALID held high
    for (int k = 0; k < 8; k++) begin
      l0 = 24'($urandom); r0 = 24'($urandom); v0 = 1;
      base = mxc[0]; c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (mxc[0] == base && c < 1000);
      #1;
      if (mxc[0] == base) chk("stream transfer timeout", 64'(c), 64'd0);
      if (k == 0) begin en = 1; a = ucnt0; end
      if (k == 1) cy1 = cyc;
      if (k == 7) cy7 = cyc;
    end
    v0 = 0;
    chk("stream underruns", 64'(ucnt0 - a), 64'd0);
    chk("stream one per frame", 64'(cy7 - cy1), 64'd1536);
    repeat (300) @(negedge clk);
    // Pair offered on the frame start edge with the buffer empty
    wfs(255);
    l0 = 24'hA5A5A5; r0 = 24'h5A5A5A; v0 = 1;
    @(negedge clk); v0 = 0;
    #1 chk("simultaneous underrun", {63'b0, und0}, 64'd1);
    chk("simultaneous pair held", {63'b0, ready0}, 64'd0);
    wfs(255);
    cap(0, sd, lr);
    chk("deferred pair", sd, 64'hA5A5A500_5A5A5A00);
    // Asynchronous reset in the right slot with the buffer full
    wfs(162);
    l0 = 24'h55AA55; r0 = 24'hAA55AA; v0 = 1;
    @(negedge clk); v0 = 0;
    #1 chk("pre-reset lrck/bclk", {62'b0, lrck0, bclk0}, 64'b11);
    chk("pre-reset full", {63'b0, ready0}, 64'd0);
    #1 rst_n = 0;
    #1 chk("mid-frame reset outputs", {59'b0, ready0, bclk0, lrck0, sdata0, und0}, 64'b10000);
    en = 0;
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk); l0 = 24'h000001; r0 = 24'h800000; v0 = 1;
    @(negedge clk); v0 = 0; en = 1;
    cap(0, sd, lr);
    chk("post-reset frame", sd, 64'h00000100_80000000);
    // Randomised traffic with occasional enable toggling
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) en = ~en;
      v0 = $urandom_range(0, 3) == 0;
      v1 = $urandom_range(0, 5) == 0;
      l0 = 24'($urandom); r0 = 24'($urandom);
      l1 = 16'($urandom); r1 = 16'($urandom);
    end
    @(negedge clk); v0 = 0; v1 = 0; en = 0;
    repeat (4) @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
